// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter merging I-cache and D-cache line requests onto one L2 port
//   clk, rst (async, active-low)
//   i_read/i_address -> i_rdata/i_resp           : instruction-cache line reads
//   d_read/d_write/d_address/d_wdata -> d_rdata/d_resp : data-cache line reads/writes
//   mem_read/mem_write/mem_address/mem_wdata256 <- mem_rdata256/mem_resp : L2 port
//   i_grants/d_grants                             : saturating per-port grant counters
module l2_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int cnt_w    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata256,
    input  logic [s_line-1:0] mem_rdata256,
    input  logic              mem_resp,
    output logic [cnt_w-1:0]  i_grants,
    output logic [cnt_w-1:0]  d_grants
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [cnt_w-1:0]  i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
    logic              d_req, grant_i, grant_d, serving;

    always_comb begin
        d_req   = d_read | d_write;
        // I wins unless D also requests and I was the last port granted
        grant_i = state_q == IDLE && i_read && (!d_req || last_d_q);
        grant_d = state_q == IDLE && d_req && !grant_i;
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        i_cnt_d  = i_cnt_q;
        d_cnt_d  = d_cnt_q;
        if (grant_i) begin
            state_d  = SERVE_I;
            last_d_d = 1'b0;
            addr_d   = i_address;
            wdata_d  = '0;
            write_d  = 1'b0;
            i_cnt_d  = i_cnt_q + cnt_w'(!(&i_cnt_q));
        end else if (grant_d) begin
            state_d  = SERVE_D;
            last_d_d = 1'b1;
            addr_d   = d_address;
            wdata_d  = d_wdata;
            write_d  = d_write;
            d_cnt_d  = d_cnt_q + cnt_w'(!(&d_cnt_q));
        end else if (state_q != IDLE && mem_resp) begin
            state_d = IDLE;
        end
        serving      = state_q != IDLE;
        mem_read     = state_q == SERVE_I || (state_q == SERVE_D && !write_q);
        mem_write    = state_q == SERVE_D && write_q;
        mem_address  = serving ? addr_q : '0;
        mem_wdata256 = serving ? wdata_q : '0;
        i_resp       = state_q == SERVE_I && mem_resp;
        d_resp       = state_q == SERVE_D && mem_resp;
        i_rdata      = i_resp ? mem_rdata256 : '0;
        d_rdata      = d_resp ? mem_rdata256 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            i_cnt_q  <= '0;
            d_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            i_cnt_q  <= i_cnt_d;
            d_cnt_q  <= d_cnt_d;
        end
    end

    assign i_grants = i_cnt_q;
    assign d_grants = d_cnt_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench for l2_arbiter with a directed L2 responder
module tb_l2_arbiter;
    logic         clk = 0;
    logic         rst = 0;
    logic         i_read = 0;
    logic [31:0]  i_address = 0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 0;
    logic         d_write = 0;
    logic [31:0]  d_address = 0;
    logic [255:0] d_wdata = 0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256 = 0;
    logic         mem_resp = 0;
    logic [7:0]   i_grants;
    logic [7:0]   d_grants;

    // narrow counters so saturation is reachable in a short run
    l2_arbiter #(.cnt_w(8)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata256(mem_wdata256), .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .i_grants(i_grants), .d_grants(d_grants)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    logic have_cur = 0;
    logic prev_busy = 0;
    logic prev_resp = 0;
    logic busy;
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic push(input logic is_d, input logic wr, input logic [31:0] a,
                        input logic [255:0] wd, input logic [255:0] rd);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = a; t.wdata = wd; t.rdata = rd;
        exp_q.push_back(t);
    endtask

    // L2 model: wait for a request, answer after lat cycles with a one-cycle mem_resp
    task automatic l2_serve(input int lat, input logic [255:0] data);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_read || mem_write) && n < 20);
        chk("l2_request_seen", mem_read | mem_write, 1);
        if (mem_read || mem_write) begin
            repeat (lat) @(posedge clk);
            #1 mem_resp = 1; mem_rdata256 = data;
            @(posedge clk);
            #1 mem_resp = 0; mem_rdata256 = 0;
        end
    endtask

    task automatic do_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    // monitor: pops the expected transaction when a request starts, checks it while served
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            have_cur = 0; prev_busy = 0; prev_resp = 0;
            chk("reset_outputs", {mem_read, mem_write, i_resp, d_resp, mem_address, i_grants, d_grants}, '0);
        end else begin
            busy = mem_read | mem_write;
            if (busy && !prev_busy) begin
                chk("request_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    if (cur.wr) chk("req_wdata", mem_wdata256, cur.wdata);
                end
            end
            if (busy && have_cur)
                chk("req_hold", {mem_address, mem_read, mem_write}, {cur.addr, !cur.wr, cur.wr});
            if (!busy) chk("idle_bus_zero", {mem_address, mem_wdata256 != 0}, '0);
            if (i_resp || d_resp) begin
                chk("resp_single_cycle", prev_resp, 0);
                chk("resp_has_txn", have_cur, 1);
                if (have_cur) begin
                    chk("resp_port", {i_resp, d_resp}, {!cur.is_d, cur.is_d});
                    chk("resp_rdata", cur.is_d ? d_rdata : i_rdata, cur.rdata);
                    have_cur = 0;
                end
            end
            if (!i_resp) chk("i_rdata_zero", i_rdata, 0);
            if (!d_resp) chk("d_rdata_zero", d_rdata, 0);
            prev_busy = busy;
            prev_resp = i_resp | d_resp;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_state", {mem_read, mem_write, i_resp, d_resp, mem_address, i_grants, d_grants}, '0);
        chk("reset_wdata", mem_wdata256, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // single I read, L2 answers after 3 cycles
        push(0, 0, 32'h60, 0, {32{8'hA5}});
        i_read = 1; i_address = 32'h60;
        @(negedge clk);
        chk("pre_grant_idle", mem_read, 0);
        @(posedge clk);
        #1 chk("grant_latency", {mem_read, mem_address}, {1'b1, 32'h60});
        l2_serve(3, {32{8'hA5}});
        i_read = 0;
        @(negedge clk);
        chk("single_counts", {i_grants, d_grants}, {8'd1, 8'd0});
        chk("single_resp_done", i_resp, 0);

        // simultaneous I read and D write after reset: I first
        do_reset();
        push(0, 0, 32'h40, 0, 256'h11);
        push(1, 1, 32'h80, 256'h1234, 256'h22);
        i_read = 1; i_address = 32'h40;
        d_write = 1; d_address = 32'h80; d_wdata = 256'h1234;
        l2_serve(1, 256'h11);
        i_read = 0;
        l2_serve(2, 256'h22);
        d_write = 0;
        @(negedge clk);
        chk("dual_counts", {i_grants, d_grants}, {8'd1, 8'd1});

        // continuous dual requests: I,D,I,D,I,D
        do_reset();
        for (int k = 0; k < 6; k++)
            push(k[0], k[0], k[0] ? 32'hD00 : 32'hC00, 256'hCAFE, 256'(k + 1));
        i_read = 1; i_address = 32'hC00;
        d_write = 1; d_address = 32'hD00; d_wdata = 256'hCAFE;
        for (int k = 0; k < 6; k++) l2_serve(1, 256'(k + 1));
        i_read = 0; d_write = 0;
        @(negedge clk);
        chk("alt_counts", {i_grants, d_grants}, {8'd3, 8'd3});

        // D request inputs change mid-service: latched values hold
        @(posedge clk);
        #1 push(1, 0, 32'h100, 0, 256'h33);
        d_read = 1; d_address = 32'h100; d_wdata = 256'h77;
        fork
            l2_serve(3, 256'h33);
            begin
                repeat (2) @(posedge clk);
                #2 d_address = 32'h200; d_write = 1;
            end
        join
        d_read = 0; d_write = 0; d_address = 0;

        // reset mid SERVE_I: abandoned, pending D granted after release
        @(posedge clk);
        #1 push(0, 0, 32'h300, 0, 256'h44);
        i_read = 1; i_address = 32'h300;
        @(posedge clk);
        @(negedge clk);
        chk("serve_i_active", mem_read, 1);
        #2 rst = 0;
        i_read = 0; d_read = 1; d_address = 32'h400;
        #1 chk("rst_abort", {mem_read, mem_write, i_resp, mem_address}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        push(1, 0, 32'h400, 0, 256'h55);
        l2_serve(1, 256'h55);
        d_read = 0;
        @(negedge clk);
        chk("post_reset_counts", {i_grants, d_grants}, {8'd0, 8'd1});

        // spurious mem_resp in IDLE
        @(posedge clk);
        #1 mem_resp = 1; mem_rdata256 = '1;
        @(negedge clk);
        chk("spurious_no_resp", {i_resp, d_resp, i_rdata != 0, d_rdata != 0}, 0);
        @(posedge clk);
        #1 mem_resp = 0; mem_rdata256 = 0;
        @(negedge clk);
        chk("spurious_stays_idle", {mem_read, mem_write}, 0);

        // back-to-back I grants saturate the counter
        do_reset();
        i_address = 32'h1000;
        for (int k = 0; k < 260; k++) begin
            push(0, 0, 32'h1000, 0, 256'(k + 7));
            if (k == 0) i_read = 1;
            l2_serve(1, 256'(k + 7));
            if (k == 254) chk("sat_reach", i_grants, 8'hFF);
        end
        i_read = 0;
        @(negedge clk);
        chk("sat_hold", {i_grants, d_grants}, {8'hFF, 8'h00});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        chk("no_open_txn", have_cur, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
